// File: rtl/sfq_rx_pkg.sv
// Shared defaults and helpers for the SFQ pulse receive path.
package sfq_rx_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;
    // Pulses on one line closer than this many clk periods alias into one.
    localparam int MIN_PULSE_GAP_CYC   = 2;

    function automatic int clog2_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sfq_edge_detect.sv
// Synchroniser plus XOR edge detector for one transition-coded line.
// The level present at reset release becomes the reference, so no pulse is reported for it.
module sfq_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic ev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [2:0]             warm_cnt_q;
    logic                   armed_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Events stay masked until the release-time level has reached prev_q.
    assign ev_o = armed_q & (level ^ prev_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            warm_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q <= level;
            if (!armed_q) begin
                warm_cnt_q <= warm_cnt_q + 3'd1;
                armed_q    <= (warm_cnt_q == 3'(SYNC_STAGES));
            end
        end
    end

endmodule

// File: rtl/sfq_pulse_deserializer.sv
// Collects one bit per SFQ-clock window from a transition-coded data line and
// hands WIDTH-bit words out over valid/ready.
module sfq_pulse_deserializer
    import sfq_rx_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int MSB_FIRST   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_t,
    input  logic                          sclk_t,
    output logic [WIDTH-1:0]              word,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          err_multi,
    output logic                          err_overflow,
    output logic [clog2_width(WIDTH)-1:0] bit_cnt
);

    localparam int CW = clog2_width(WIDTH);

    // Handshake: word is offered while word_valid=1 and is consumed on any
    // clk edge where word_valid & word_ready; word is frozen until then.

    logic             d_ev, c_ev;
    logic [WIDTH-1:0] shift_q, shift_d, shifted;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             pending_q, pending_d;
    logic             valid_q, valid_d;
    logic             err_multi_q, err_multi_d;
    logic             err_ovf_q, err_ovf_d;
    logic             win_bit;

    sfq_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_data_edge (
        .clk    (clk),
        .rst    (rst),
        .line_i (din_t),
        .ev_o   (d_ev)
    );

    sfq_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_edge (
        .clk    (clk),
        .rst    (rst),
        .line_i (sclk_t),
        .ev_o   (c_ev)
    );

    // A data pulse coincident with the clock pulse belongs to the closing window.
    assign win_bit = pending_q | d_ev;
    assign shifted = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], win_bit}
                                      : {win_bit, shift_q[WIDTH-1:1]};

    always_comb begin
        shift_d     = shift_q;
        pending_d   = pending_q;
        bit_cnt_d   = bit_cnt_q;
        word_d      = word_q;
        valid_d     = valid_q;
        err_multi_d = err_multi_q;
        err_ovf_d   = err_ovf_q;

        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end

        if (c_ev) begin
            shift_d   = shifted;
            pending_d = 1'b0;
            if (pending_q && d_ev) begin
                err_multi_d = 1'b1;
            end
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
                bit_cnt_d = '0;
                if (!valid_q || word_ready) begin
                    word_d  = shifted;
                    valid_d = 1'b1;
                end else begin
                    err_ovf_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end else if (d_ev) begin
            if (pending_q) begin
                err_multi_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            pending_q   <= 1'b0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            err_multi_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            pending_q   <= pending_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            err_multi_q <= err_multi_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign word         = word_q;
    assign word_valid   = valid_q;
    assign err_multi    = err_multi_q;
    assign err_overflow = err_ovf_q;
    assign bit_cnt      = bit_cnt_q;

endmodule

// File: doc/sfq_pulse_deserializer.md
Name: sfq_pulse_deserializer

Overview:
- Downstream consumer of the transition-coded buffer stage (BUFFT family). Every level change on a line is one SFQ pulse.
- Samples two transition lines with the system clock:
  - a data line, driven from the buffer output q;
  - an SFQ clock line.
- Each SFQ-clock pulse closes one bit window: bit = 1 if a data pulse arrived in that window, else 0.
- Packs WIDTH bits into a word and hands it to conventional logic over a valid/ready handshake, for co-simulation checks and readout of RSFQ chains.

Parameters:
- WIDTH, 8: bits per output word; legal range 2..32.
- SYNC_STAGES, 2: synchroniser flops per transition input; legal range 2..4.
- MSB_FIRST, 1: 1 = first window lands in word[WIDTH-1]; 0 = first window lands in word[0].

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- din_t  in  1  data transition line (buffer q); each level change is one data pulse.
- sclk_t  in  1  SFQ clock transition line; each level change closes a window.
- word  out  WIDTH  assembled word; stable while word_valid=1.
- word_valid  out  1  word holds an unconsumed word.
- word_ready  in  1  consumer accepts word when word_valid & word_ready.
- err_multi  out  1  sticky: at least one window saw more than one data pulse.
- err_overflow  out  1  sticky: a completed word was dropped because the output was full.
- bit_cnt  out  $clog2(WIDTH+1)  windows closed in the current word (debug).

Behaviour:
- Reset (async assert, sync release by the design around it):
  - Synchroniser flops and the previous-level registers = 0.
  - shift register = 0, pending = 0, bit_cnt = 0, word = 0.
  - word_valid = 0, err_multi = 0, err_overflow = 0.
  - The line level present at release is taken as the reference level. No spurious pulse is counted even if din_t or sclk_t sit at 1.
- Edge detection:
  - d_ev = sync(din_t) XOR prev_d.
  - c_ev = sync(sclk_t) XOR prev_c.
  - prev_* updates every cycle.
  - Pulses must be at least 2 clk periods apart per line. Closer pulses alias and are out of contract.
- Window state per clk cycle (pending = data pulse seen in the open window):
  - d_ev & !c_ev: if pending already 1, set err_multi; else pending <= 1.
  - c_ev (with or without d_ev): bit = pending | d_ev. Shift bit into the shift register; pending <= 0; bit_cnt++.
    - Simultaneous d_ev & c_ev: the data pulse belongs to the closing window (data precedes clock in RSFQ timing).
    - If pending=1 and d_ev=1 in that same cycle, set err_multi.
  - No events: hold.
- Word completion: on the c_ev cycle where bit_cnt reaches WIDTH:
  - If output empty (word_valid=0), or a transfer happens this same cycle: word <= shifted value, word_valid <= 1 next cycle.
  - Else: drop the word, set err_overflow, keep the old word.
  - bit_cnt <= 0 in both cases. Collection continues without a gap.
- Handshake:
  - word_valid deasserts the cycle after valid & ready unless a new word loads on that same edge.
  - word must not change while valid & !ready.
- Latency: a line change reaches the edge detector SYNC_STAGES cycles after sampling. word_valid rises SYNC_STAGES+1 clk cycles after the level change of the WIDTH-th SFQ-clock pulse.
- Sticky errors clear only on rst.
- rst mid-word discards the partial word and any held word.

Decomposition:
- Shared package sfq_rx_pkg holds:
  - the default WIDTH and SYNC_STAGES;
  - function clog2_width;
  - localparam MIN_PULSE_GAP_CYC = 2.
- Sub-module sfq_edge_detect: N-stage synchroniser plus XOR edge detector, one instance per transition line, with reset-level capture.

Test Plan:
- Reset release with din_t=1, sclk_t=1 held, no further edges -> word_valid=0, bit_cnt=0, both errors 0 after 20 cycles.
- WIDTH=8, MSB_FIRST=1, word_ready=1; data pulse before windows 1,3,4,8 (pattern 1011_0001), eight clock pulses spaced 6 cycles -> word=8'hB1, word_valid high exactly one cycle, err_multi=0.
- Data and SFQ-clock toggles sampled on the same clk edge in every window (data in all windows) -> word=8'hFF, no errors.
- Two data pulses 3 cycles apart inside window 2 -> err_multi=1 and stays 1; bit 2 still recorded as 1.
- word_ready=0, two full words sent (8'h5A then 8'h3C) -> word stays 8'h5A, err_overflow=1; raise ready -> 8'h5A consumed, word_valid drops.
- rst pulsed after 5 windows of a word -> bit_cnt=0, word_valid=0; the next 8 windows carrying 8'h81 yield exactly 8'h81.
